// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALUOp and ALUControl codes.
package ctrl_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BEQ,
        JAL
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTL_W-1:0] ALUCTL_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALUCTL_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALUCTL_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALUCTL_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from ALUOp and the instruction's funct fields.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALUCTL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUCTL_ADD;
            ALUOP_SUB: ALUControl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  ALUControl = ALUCTL_SLT;
                    3'b110:  ALUControl = ALUCTL_OR;
                    3'b111:  ALUControl = ALUCTL_AND;
                    default: ALUControl = ALUCTL_ADD;
                endcase
            end
            default: ALUControl = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle RISC-V control FSM with write enables forced off during reset.
// Define MEM_HANDSHAKE_EN to make FETCH/MEMREAD/MEMWRITE wait for mem_ready.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_mem_ok;
    logic       w_mem_req;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_branch;
    logic       w_pc_update;
    logic       w_illegal;

`ifdef MEM_HANDSHAKE_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_mem_ok           = 1'b1;
    assign w_unused_mem_ready = mem_ready;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = FETCH;
        w_mem_req   = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_pc_update = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = ALUOP_ADD;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_req   = 1'b1;
                w_ir_write  = w_mem_ok;
                w_pc_update = w_mem_ok;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_next      = w_mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTER;
                    OP_ITYPE:     w_next = EXECUTEI;
                    OP_JAL:       w_next = JAL;
                    OP_BEQ:       w_next = BEQ;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                w_mem_req = 1'b1;
                AdrSrc    = 1'b1;
                w_next    = w_mem_ok ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            MEMWRITE: begin
                w_mem_req   = 1'b1;
                AdrSrc      = 1'b1;
                w_mem_write = w_mem_ok;
                w_next      = w_mem_ok ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            ALUWB: w_reg_write = 1'b1;
            BEQ: begin
                ALUSrcA  = 2'b10;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            default: w_next = FETCH;
        endcase
    end

    // Immediate format depends only on the opcode, not on the state.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign mem_req    = rst_n & w_mem_req;
    assign PCWrite    = rst_n & ((w_branch & zero) | w_pc_update);
    assign IRWrite    = rst_n & w_ir_write;
    assign MemWrite   = rst_n & w_mem_write;
    assign RegWrite   = rst_n & w_reg_write;
    assign illegal_op = rst_n & w_illegal;

    alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller; handshake corner cases follow MEM_HANDSHAKE_EN.
module tb_multicycle_controller;

    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPB = 7'b1100011;
    localparam logic [6:0] OPJ = 7'b1101111;
    localparam logic [6:0] OPX = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] w_act;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op)
    );

    assign w_act = {mem_req, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack expected outputs in the same order as w_act.
    function automatic logic [17:0] ex(input logic mreq, input logic pcw, input logic irw,
                                       input logic mw, input logic rw, input logic adr,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic ill);
        return {mreq, pcw, irw, mw, rw, adr, rs, a, b, imm, alu, ill};
    endfunction

    function automatic logic [17:0] fe(input logic [1:0] imm);
        return ex(1, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [17:0] feg(input logic [1:0] imm);
        return ex(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0);
    endfunction

    function automatic logic [17:0] de(input logic [1:0] imm);
        return ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0);
    endfunction

    function automatic logic [17:0] wb(input logic [1:0] imm);
        return ex(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    endfunction

    task automatic add(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [17:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then advance past the rising edge.
    task automatic cyc(input string nm, input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic rdy, input logic [17:0] e);
        rst_n = r; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
        @(negedge clk);
        n_checks++;
        if (w_act !== e) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, w_act, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op = OPR; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // R-type sub: reset state, then FETCH, DECODE, EXECUTER, ALUWB
        add(0, OPR, 3'b000, 1, 0, feg(2'b00));
        add(1, OPR, 3'b000, 1, 0, fe(2'b00));
        add(1, OPR, 3'b000, 1, 0, de(2'b00));
        add(1, OPR, 3'b000, 1, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
        add(1, OPR, 3'b000, 1, 0, wb(2'b00));
        // I-type andi (funct7b5 ignored because op[5]=0)
        add(1, OPI, 3'b111, 1, 0, fe(2'b00));
        add(1, OPI, 3'b111, 1, 0, de(2'b00));
        add(1, OPI, 3'b111, 1, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010, 0));
        add(1, OPI, 3'b111, 1, 0, wb(2'b00));
        // beq taken, then not taken
        add(1, OPB, 3'b000, 0, 1, fe(2'b10));
        add(1, OPB, 3'b000, 0, 1, de(2'b10));
        add(1, OPB, 3'b000, 0, 1, ex(0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        add(1, OPB, 3'b000, 0, 0, fe(2'b10));
        add(1, OPB, 3'b000, 0, 0, de(2'b10));
        add(1, OPB, 3'b000, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
        // lw: five states
        add(1, OPL, 3'b010, 0, 0, fe(2'b00));
        add(1, OPL, 3'b010, 0, 0, de(2'b00));
        add(1, OPL, 3'b010, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        add(1, OPL, 3'b010, 0, 0, ex(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        add(1, OPL, 3'b010, 0, 0, ex(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        // sw: four states
        add(1, OPS, 3'b010, 0, 0, fe(2'b01));
        add(1, OPS, 3'b010, 0, 0, de(2'b01));
        add(1, OPS, 3'b010, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        add(1, OPS, 3'b010, 0, 0, ex(1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        // jal
        add(1, OPJ, 3'b000, 0, 0, fe(2'b11));
        add(1, OPJ, 3'b000, 0, 0, de(2'b11));
        add(1, OPJ, 3'b000, 0, 0, ex(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
        add(1, OPJ, 3'b000, 0, 0, wb(2'b11));
        // illegal opcode: pulse in DECODE, back to FETCH
        add(1, OPX, 3'b000, 0, 0, fe(2'b00));
        add(1, OPX, 3'b000, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1));
        // slt and or
        add(1, OPR, 3'b010, 0, 0, fe(2'b00));
        add(1, OPR, 3'b010, 0, 0, de(2'b00));
        add(1, OPR, 3'b010, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 0));
        add(1, OPR, 3'b010, 0, 0, wb(2'b00));
        add(1, OPR, 3'b110, 0, 0, fe(2'b00));
        add(1, OPR, 3'b110, 0, 0, de(2'b00));
        add(1, OPR, 3'b110, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b011, 0));
        add(1, OPR, 3'b110, 0, 0, wb(2'b00));
        // reset during MEMWRITE kills MemWrite at once, then FETCH
        add(1, OPS, 3'b010, 0, 0, fe(2'b01));
        add(1, OPS, 3'b010, 0, 0, de(2'b01));
        add(1, OPS, 3'b010, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        add(0, OPS, 3'b010, 0, 0, ex(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        add(1, OPR, 3'b000, 1, 0, fe(2'b00));
        // reset during EXECUTER abandons the instruction
        add(1, OPR, 3'b000, 1, 0, de(2'b00));
        add(0, OPR, 3'b000, 1, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
        add(0, OPR, 3'b000, 1, 0, feg(2'b00));
        add(1, OPR, 3'b000, 1, 0, fe(2'b00));

        foreach (vecs[i])
            cyc($sformatf("row%0d", i), vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7,
                vecs[i].z, 1'b1, vecs[i].exp);

        // State is DECODE here; reset back to FETCH before the mem_ready sequences.
        cyc("resync", 0, OPR, 3'b000, 1, 0, 1, de(2'b00));

`ifdef MEM_HANDSHAKE_EN
        cyc("hs_fetch_wait", 1, OPL, 3'b010, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
        cyc("hs_fetch_done", 1, OPL, 3'b010, 0, 0, 1, fe(2'b00));
        cyc("hs_decode",     1, OPL, 3'b010, 0, 0, 1, de(2'b00));
        cyc("hs_memadr",     1, OPL, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        for (int k = 0; k < 3; k++)
            cyc($sformatf("hs_memread_wait%0d", k), 1, OPL, 3'b010, 0, 0, 0,
                ex(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        cyc("hs_memread_done", 1, OPL, 3'b010, 0, 0, 1, ex(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        cyc("hs_memwb",      1, OPL, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        cyc("hs_sw_fetch",   1, OPS, 3'b010, 0, 0, 1, fe(2'b01));
        cyc("hs_sw_decode",  1, OPS, 3'b010, 0, 0, 1, de(2'b01));
        cyc("hs_sw_memadr",  1, OPS, 3'b010, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        cyc("hs_memwr_wait", 1, OPS, 3'b010, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        cyc("hs_memwr_done", 1, OPS, 3'b010, 0, 0, 1, ex(1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        cyc("hs_refetch",    1, OPS, 3'b010, 0, 0, 1, fe(2'b01));
`else
        cyc("nr_fetch",      1, OPL, 3'b010, 0, 0, 0, fe(2'b00));
        cyc("nr_decode",     1, OPL, 3'b010, 0, 0, 0, de(2'b00));
        cyc("nr_memadr",     1, OPL, 3'b010, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
        cyc("nr_memread",    1, OPL, 3'b010, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        cyc("nr_memwb",      1, OPL, 3'b010, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        cyc("nr_sw_fetch",   1, OPS, 3'b010, 0, 0, 0, fe(2'b01));
        cyc("nr_sw_decode",  1, OPS, 3'b010, 0, 0, 0, de(2'b01));
        cyc("nr_sw_memadr",  1, OPS, 3'b010, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
        cyc("nr_memwrite",   1, OPS, 3'b010, 0, 0, 0, ex(1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
        cyc("nr_refetch",    1, OPS, 3'b010, 0, 0, 0, fe(2'b01));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
